// File: rtl/serial_mag_compare_ctrl_pkg.sv
// serial_mag_compare_ctrl_pkg: shared state encoding and result codes
package serial_mag_compare_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic [2:0] RES_LT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_GT = 3'b001;
endpackage

// File: rtl/comparator_1bit.sv
// comparator_1bit: single-bit magnitude compare cell
module comparator_1bit (
  input  logic A,
  input  logic B,
  output logic A_lt_B,
  output logic A_eq_B,
  output logic A_gt_B
);
  assign A_lt_B = ~A & B;
  assign A_eq_B = ~(A ^ B);
  assign A_gt_B = A & ~B;
endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// serial_mag_compare_ctrl: MSB-first bit-serial magnitude comparator controller
module serial_mag_compare_ctrl
  import serial_mag_compare_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic [CNT_W-1:0] bits_examined
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
  state_t state, state_d;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IDX_W-1:0] idx;
  logic c_lt, c_eq, c_gt;
  comparator_1bit u_cmp (
    .A(a_reg[idx]),
    .B(b_reg[idx]),
    .A_lt_B(c_lt),
    .A_eq_B(c_eq),
    .A_gt_B(c_gt)
  );
  always_comb begin
    state_d = state;
    state_d = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? ((c_eq && idx != '0) ? RUN : DONE) : IDLE;
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      idx <= IDX_TOP;
      bits_examined <= '0;
      {a_lt_b, a_eq_b, a_gt_b} <= 3'b000;
    end else begin
      state <= state_d;
      if (state == IDLE && start) begin
        a_reg <= a;
        b_reg <= b;
        idx <= IDX_TOP;
        bits_examined <= '0;
        {a_lt_b, a_eq_b, a_gt_b} <= 3'b000;
      end
      if (state == RUN) begin
        bits_examined <= bits_examined + CNT_W'(1);
        if (!c_eq || idx == '0) {a_lt_b, a_eq_b, a_gt_b} <= {c_lt, c_eq, c_gt};
        else idx <= idx - IDX_W'(1);
      end
    end
  end
endmodule
